load_store_unit: RTL and testbench

- Sits between the core's memory stage and DataMemory.
- Converts byte, halfword and word loads and stores into word-only DataMemory accesses.
- Sub-word stores are done as read-modify-write; loads are sign- or zero-extended.
- Checks alignment, range and funct3 before any memory access.
- Multi-cycle; talks to the core through a valid/ready request port and a one-cycle response pulse.

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Byte/half/word load-store front end for a word-only DataMemory.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_RMW_READ  = 3'd2,
        S_RMW_WRITE = 3'd3,
        S_STORE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic [15:0] wdata_lo_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_write_q;
    logic        mem_read_q;

    logic        req_err_d;
    logic [7:0]  byte_sel_d;
    logic [15:0] half_sel_d;
    logic [31:0] load_data_d;
    logic [31:0] merge_data_d;

    // Request checks use the raw request fields so errors never touch memory.
    always_comb begin
        req_err_d = 1'b0;
        if (req_we && (req_funct3 > 3'd2))
            req_err_d = 1'b1;
        if (!req_we && ((req_funct3 == 3'd3) || (req_funct3 > 3'd5)))
            req_err_d = 1'b1;
        if ((req_funct3[1:0] == 2'd1) && req_addr[0])
            req_err_d = 1'b1;
        if ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0))
            req_err_d = 1'b1;
        if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
            req_err_d = 1'b1;
    end

    always_comb begin
        byte_sel_d = 8'(mem_rdata >> {addr_lo_q, 3'b000});
        half_sel_d = 16'(mem_rdata >> {addr_lo_q[1], 4'b0000});
        unique case (funct3_q)
            3'd0:    load_data_d = {{24{byte_sel_d[7]}}, byte_sel_d};
            3'd1:    load_data_d = {{16{half_sel_d[15]}}, half_sel_d};
            3'd4:    load_data_d = {24'd0, byte_sel_d};
            3'd5:    load_data_d = {16'd0, half_sel_d};
            default: load_data_d = mem_rdata;
        endcase
    end

    // Sub-word merge: the fetched word with only the addressed lane replaced.
    always_comb begin
        merge_data_d = mem_rdata;
        if (funct3_q[1:0] == 2'd0)
            merge_data_d[{addr_lo_q, 3'b000} +: 8] = wdata_lo_q[7:0];
        else
            merge_data_d[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            funct3_q     <= 3'd0;
            addr_lo_q    <= 2'd0;
            wdata_lo_q   <= 16'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q   <= req_funct3;
                        addr_lo_q  <= req_addr[1:0];
                        wdata_lo_q <= req_wdata[15:0];
                        if (req_err_d) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_addr_q <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                state_q    <= S_LOAD;
                                mem_read_q <= 1'b1;
                            end else if (req_funct3 == 3'd2) begin
                                state_q     <= S_STORE;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= req_wdata;
                            end else begin
                                state_q    <= S_RMW_READ;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    state_q      <= S_DONE;
                    mem_read_q   <= 1'b0;
                    mem_addr_q   <= 32'd0;
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= load_data_d;
                end
                S_RMW_READ: begin
                    state_q     <= S_RMW_WRITE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    mem_wdata_q <= merge_data_d;
                end
                S_STORE, S_RMW_WRITE: begin
                    state_q      <= S_DONE;
                    mem_write_q  <= 1'b0;
                    mem_wdata_q  <= 32'd0;
                    mem_addr_q   <= 32'd0;
                    resp_valid_q <= 1'b1;
                    resp_error_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_write  = mem_write_q;
    assign mem_read   = mem_read_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized bench for load_store_unit against a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_rdata;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    // DataMemory as seen by the DUT, and the bench's own expected contents.
    logic [31:0] dmem    [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    assign mem_rdata = mem_read ? dmem[mem_addr[11:2]] : 32'h0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_rd  = 0;
    int          n_wr  = 0;
    int          bad_addr = 0;
    logic [31:0] exp_maddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: sample at the falling edge and service any memory write.
    task automatic tick();
        @(negedge clock);
        chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
        if ((mem_read || mem_write) && (mem_addr !== exp_maddr))
            bad_addr++;
        if (mem_read)
            n_rd++;
        if (mem_write) begin
            n_wr++;
            last_wdata = mem_wdata;
            dmem[mem_addr[11:2]] = mem_wdata;
        end
    endtask

    // Reference behaviour derived from byte-level arithmetic on the word store.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic [31:0] wd, output logic err,
                         output int lat, output int rd, output int wr);
        longint size, b, idx, mask, v;
        logic   illegal;
        idx     = longint'(addr >> 2);
        b       = longint'(addr % 4);
        size    = longint'(1) << (f3 % 4);
        illegal = we ? (f3 > 3'd2) : ((f3 == 3'd3) || (f3 > 3'd5));
        err     = illegal || ((addr % size) != 0) || (idx >= MEM_WORDS);
        rdata = 32'h0; wd = 32'h0; lat = 1; rd = 0; wr = 0;
        if (!err && !we) begin
            v = (ref_mem[idx] >> (8 * b)) & ((64'd1 << (8 * size)) - 1);
            if (f3 < 3'd4 && size < 4 && v >= (64'd1 << (8 * size - 1)))
                v = v - (64'd1 << (8 * size));
            rdata = v[31:0];
            lat = 2; rd = 1;
        end else if (!err) begin
            mask = ((64'd1 << (8 * size)) - 1) << (8 * b);
            v = ({32'd0, ref_mem[idx]} & ~mask) | (({32'd0, wdata} << (8 * b)) & mask);
            wd = v[31:0];
            ref_mem[idx] = wd;
            lat = (size == 4) ? 2 : 3;
            rd  = (size == 4) ? 0 : 1;
            wr  = 1;
        end
    endtask

    task automatic run_chk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err);
        logic [31:0] e_rdata, e_wdata;
        logic        e_err;
        int          e_lat, e_rd, e_wr, lat, rd0, wr0;
        model(we, f3, addr, wdata, e_rdata, e_wdata, e_err, e_lat, e_rd, e_wr);
        chk("ready_idle", 32'(req_ready), 32'h1);
        exp_maddr = {addr[31:2], 2'b00};
        bad_addr  = 0;
        rd0 = n_rd;
        wr0 = n_wr;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        chk("ready_busy", 32'(req_ready), 32'h0);
        // Request fields are don't-care once accepted; a stray valid must be ignored.
        req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk("resp_seen", 32'(resp_valid), 32'h1);
        rdata = resp_rdata;
        err   = resp_error;
        chk("rdata", rdata, e_rdata);
        chk("error", 32'(err), 32'(e_err));
        chk("latency", 32'(lat), 32'(e_lat));
        chk("read_cycles", 32'(n_rd - rd0), 32'(e_rd));
        chk("write_cycles", 32'(n_wr - wr0), 32'(e_wr));
        chk("mem_addr", 32'(bad_addr), 32'h0);
        if (e_wr != 0)
            chk("mem_wdata", last_wdata, e_wdata);
        req_valid = 1'b0;
        tick();
        chk("resp_pulse", 32'(resp_valid), 32'h0);
    endtask

    logic [31:0] r;
    logic        e;
    logic [31:0] v0;
    int          wr_before;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            v0 = $urandom;
            dmem[i]    = v0;
            ref_mem[i] = v0;
        end
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_error", 32'(resp_error), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_ready", 32'(req_ready), 32'h1);
            chk("idle_resp", 32'(resp_valid), 32'h0);
            chk("idle_strobes", 32'({mem_read, mem_write}), 32'h0);
        end

        run_chk(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, r, e);
        run_chk(1'b0, 3'd2, 32'h10, 32'h0, r, e);
        chk("lw_deadbeef", r, 32'hDEADBEEF);
        run_chk(1'b0, 3'd0, 32'h13, 32'h0, r, e);
        chk("lb_0x13", r, 32'hFFFFFFDE);
        run_chk(1'b0, 3'd4, 32'h13, 32'h0, r, e);
        chk("lbu_0x13", r, 32'h000000DE);
        run_chk(1'b0, 3'd1, 32'h12, 32'h0, r, e);
        chk("lh_0x12", r, 32'hFFFFDEAD);
        run_chk(1'b0, 3'd5, 32'h10, 32'h0, r, e);
        chk("lhu_0x10", r, 32'h0000BEEF);
        run_chk(1'b1, 3'd0, 32'h11, 32'h55, r, e);
        run_chk(1'b0, 3'd2, 32'h10, 32'h0, r, e);
        chk("sb_merge", r, 32'hDEAD55EF);

        run_chk(1'b0, 3'd2, 32'h02, 32'h0, r, e);
        chk("err_lw_misaligned", 32'(e), 32'h1);
        run_chk(1'b1, 3'd1, 32'h21, 32'h1234, r, e);
        chk("err_sh_misaligned", 32'(e), 32'h1);
        run_chk(1'b0, 3'd2, 32'h1000, 32'h0, r, e);
        chk("err_out_of_range", 32'(e), 32'h1);
        run_chk(1'b0, 3'd3, 32'h10, 32'h0, r, e);
        chk("err_funct3", 32'(e), 32'h1);

        // Reset while the read half of a read-modify-write is in flight.
        exp_maddr = 32'h20;
        wr_before = n_wr;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h20; req_wdata = 32'hAB;
        tick();
        req_valid = 1'b0;
        chk("abort_in_rmw_read", 32'(mem_read), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_no_write", 32'(mem_write), 32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        tick();
        chk("abort_write_count", 32'(n_wr - wr_before), 32'h0);
        run_chk(1'b0, 3'd2, 32'h20, 32'h0, r, e);

        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            if ($urandom_range(15) == 0)
                a = $urandom;
            else
                a = {25'd0, 5'($urandom_range(31)), 2'($urandom)};
            run_chk(1'($urandom), 3'($urandom), a, $urandom, r, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
